// File: rtl/serial_word_rx.sv
// Deserialises the FT2 ser_clk/ser_dat pair into WORD_W-bit words. Both lines
// are oversampled in clk_32. Each word is presented on a valid/ready port.
// Partial frames are discarded on timeout. Dropped words raise a sticky overrun flag.
module serial_word_rx #(
    parameter int unsigned WORD_W      = 32,
    parameter int unsigned TIMEOUT_CYC = 64,
    parameter int unsigned ERRCNT_W    = 8
) (
    input  logic                clk_32,
    input  logic                rst_n,
    input  logic                ser_clk_in,
    input  logic                ser_dat_in,
    output logic [WORD_W-1:0]   word_out,
    output logic                word_valid,
    input  logic                word_ready,
    output logic [5:0]          bit_cnt,
    output logic                frame_err,
    output logic                overrun,
    output logic [ERRCNT_W-1:0] err_count
);

    localparam int unsigned TMR_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam int unsigned CNT_W = 6;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RECV = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic                clk_s1, clk_s2, clk_s3;
    logic                dat_s1, dat_s2;
    logic                fall;
    logic [WORD_W-1:0]   shreg;
    logic [TMR_W-1:0]    timer;
    logic [TMR_W-1:0]    timer_nxt;
    logic [CNT_W-1:0]    cnt_nxt;
    logic                shift_en;
    logic                timeout;
    logic                deliver;
    logic                drop;
    logic [1:0]          err_inc;
    logic [ERRCNT_W:0]   err_sum;

    assign fall    = clk_s3 & ~clk_s2;
    assign err_inc = {1'b0, timeout} + {1'b0, drop};
    assign err_sum = {1'b0, err_count} + (ERRCNT_W+1)'(err_inc);

    // Two-flop synchronisers; the extra clock stage gives the falling-edge detect.
    always_ff @(posedge clk_32 or negedge rst_n) begin
        if (!rst_n) begin
            clk_s1 <= 1'b0;
            clk_s2 <= 1'b0;
            clk_s3 <= 1'b0;
            dat_s1 <= 1'b0;
            dat_s2 <= 1'b0;
        end else begin
            clk_s1 <= ser_clk_in;
            clk_s2 <= clk_s1;
            clk_s3 <= clk_s2;
            dat_s1 <= ser_dat_in;
            dat_s2 <= dat_s1;
        end
    end

    // Frame state register.
    always_ff @(posedge clk_32 or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and datapath controls; a fall seen in DONE starts the next frame.
    always_comb begin
        state_nxt = state;
        shift_en  = 1'b0;
        cnt_nxt   = bit_cnt;
        timer_nxt = '0;
        timeout   = 1'b0;
        deliver   = 1'b0;
        drop      = 1'b0;
        case (state)
            S_IDLE: begin
                cnt_nxt = '0;
                if (fall) begin
                    shift_en  = 1'b1;
                    cnt_nxt   = CNT_W'(1);
                    state_nxt = S_RECV;
                end
            end
            S_RECV: begin
                if (fall) begin
                    shift_en = 1'b1;
                    if (bit_cnt == CNT_W'(WORD_W - 1)) begin
                        cnt_nxt   = '0;
                        state_nxt = S_DONE;
                    end else begin
                        cnt_nxt = bit_cnt + CNT_W'(1);
                    end
                end else if (timer == TMR_W'(TIMEOUT_CYC - 1)) begin
                    timeout   = 1'b1;
                    cnt_nxt   = '0;
                    state_nxt = S_IDLE;
                end else begin
                    timer_nxt = timer + TMR_W'(1);
                end
            end
            S_DONE: begin
                if (!word_valid || word_ready) begin
                    deliver = 1'b1;
                end else begin
                    drop = 1'b1;
                end
                if (fall) begin
                    shift_en  = 1'b1;
                    cnt_nxt   = CNT_W'(1);
                    state_nxt = S_RECV;
                end else begin
                    cnt_nxt   = '0;
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                cnt_nxt   = '0;
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Shift register, bit counter and inter-bit timer.
    always_ff @(posedge clk_32 or negedge rst_n) begin
        if (!rst_n) begin
            shreg   <= '0;
            bit_cnt <= '0;
            timer   <= '0;
        end else begin
            bit_cnt <= cnt_nxt;
            timer   <= timer_nxt;
            if (timeout) begin
                shreg <= '0;
            end else if (shift_en) begin
                shreg <= {shreg[WORD_W-2:0], dat_s2};
            end
        end
    end

    // Output word holding register and valid/ready handshake.
    always_ff @(posedge clk_32 or negedge rst_n) begin
        if (!rst_n) begin
            word_out   <= '0;
            word_valid <= 1'b0;
        end else if (deliver) begin
            word_out   <= shreg;
            word_valid <= 1'b1;
        end else if (word_valid && word_ready) begin
            word_valid <= 1'b0;
        end
    end

    // Error reporting: timeout pulse, sticky overrun, saturating event counter.
    always_ff @(posedge clk_32 or negedge rst_n) begin
        if (!rst_n) begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            err_count <= '0;
        end else begin
            frame_err <= timeout;
            overrun   <= overrun | drop;
            if (err_sum[ERRCNT_W]) begin
                err_count <= '1;
            end else begin
                err_count <= err_sum[ERRCNT_W-1:0];
            end
        end
    end

endmodule
